// File: rtl/cramer_divider_if.sv
// Operand and result handshake bundle for cramer_divider.
// All magnitudes are W bits with a separate sign bit (1 = negative).
interface cramer_divider_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] det_mag;
  logic         det_sign;
  logic [W-1:0] dx_mag;
  logic         dx_sign;
  logic [W-1:0] dy_mag;
  logic         dy_sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_mag;
  logic         x_sign;
  logic [W-1:0] xr_mag;
  logic         xr_sign;
  logic [W-1:0] y_mag;
  logic         y_sign;
  logic [W-1:0] yr_mag;
  logic         yr_sign;
  logic         div_zero;

  modport master (
    output in_valid, det_mag, det_sign, dx_mag, dx_sign, dy_mag, dy_sign, out_ready,
    input  in_ready, out_valid, x_mag, x_sign, xr_mag, xr_sign,
           y_mag, y_sign, yr_mag, yr_sign, div_zero
  );

  modport slave (
    input  in_valid, det_mag, det_sign, dx_mag, dx_sign, dy_mag, dy_sign, out_ready,
    output in_ready, out_valid, x_mag, x_sign, xr_mag, xr_sign,
           y_mag, y_sign, yr_mag, yr_sign, div_zero
  );
endinterface

// File: rtl/cramer_divider.sv
// Finishes Cramer's rule for a 2x2 system: x = dx/det then y = dy/det,
// sharing one restoring divider on sign-magnitude operands (truncate toward zero).
module cramer_divider #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cramer_divider_if.slave io
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DIVX, DIVY, DONE} state_t;

  state_t         state, next_state;
  logic           accept;
  logic           last;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem;
  logic [W-1:0]   dvd;
  logic [W-1:0]   det_m;
  logic [W-1:0]   dy_m;
  logic           det_s, dx_s, dy_s;
  logic [W:0]     shifted;
  logic           borrow;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   x_m, xr_m, y_m, yr_m;
  logic           x_s, xr_s, y_s, yr_s, dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = (cnt == '0);
    case (state)
      IDLE: if (io.in_valid) begin
        accept     = 1'b1;
        next_state = (io.det_mag == '0) ? DONE : DIVX;
      end
      DIVX:    if (last) next_state = DIVY;
      DIVY:    if (last) next_state = DONE;
      DONE:    if (io.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient register: each step
  // shifts the next dividend bit out of the top and the new quotient bit in.
  always_comb begin
    shifted  = {rem, dvd[W-1]};
    borrow   = (shifted < {1'b0, det_m});
    rem_next = borrow ? shifted[W-1:0] : (shifted[W-1:0] - det_m);
    quo_next = {dvd[W-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      det_m <= '0;
      dy_m  <= '0;
      det_s <= 1'b0;
      dx_s  <= 1'b0;
      dy_s  <= 1'b0;
      x_m   <= '0;
      xr_m  <= '0;
      y_m   <= '0;
      yr_m  <= '0;
      x_s   <= 1'b0;
      xr_s  <= 1'b0;
      y_s   <= 1'b0;
      yr_s  <= 1'b0;
      dz    <= 1'b0;
    end else if (accept) begin
      det_m <= io.det_mag;
      det_s <= io.det_sign;
      dx_s  <= io.dx_sign;
      dy_m  <= io.dy_mag;
      dy_s  <= io.dy_sign;
      dvd   <= io.dx_mag;
      rem   <= '0;
      cnt   <= CW'(W-1);
      dz    <= (io.det_mag == '0);
      if (io.det_mag == '0) begin
        x_m  <= '0;
        xr_m <= '0;
        y_m  <= '0;
        yr_m <= '0;
        x_s  <= 1'b0;
        xr_s <= 1'b0;
        y_s  <= 1'b0;
        yr_s <= 1'b0;
      end
    end else if (state == DIVX || state == DIVY) begin
      if (!last) begin
        dvd <= quo_next;
        rem <= rem_next;
        cnt <= cnt - 1'b1;
      end else if (state == DIVX) begin
        x_m  <= quo_next;
        x_s  <= (|quo_next) & (dx_s ^ det_s);
        xr_m <= rem_next;
        xr_s <= (|rem_next) & dx_s;
        dvd  <= dy_m;
        rem  <= '0;
        cnt  <= CW'(W-1);
      end else begin
        y_m  <= quo_next;
        y_s  <= (|quo_next) & (dy_s ^ det_s);
        yr_m <= rem_next;
        yr_s <= (|rem_next) & dy_s;
      end
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.x_mag     = x_m;
  assign io.x_sign    = x_s;
  assign io.xr_mag    = xr_m;
  assign io.xr_sign   = xr_s;
  assign io.y_mag     = y_m;
  assign io.y_sign    = y_s;
  assign io.yr_mag    = yr_m;
  assign io.yr_sign   = yr_s;
  assign io.div_zero  = dz;

endmodule

// File: tb/tb_cramer_divider.sv
// Randomized and directed bench for cramer_divider, checked against an
// integer-arithmetic model of sign-magnitude Cramer division.
module tb_cramer_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cramer_divider_if #(.W(W)) io ();

  cramer_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  logic [36:0] got;
  assign got = {io.x_sign, io.x_mag, io.xr_sign, io.xr_mag,
                io.y_sign, io.y_mag, io.yr_sign, io.yr_mag, io.div_zero};

  // Truncating division with zero magnitudes always reported as positive.
  function automatic logic [36:0] model(input int dm, input int ds, input int xm,
                                        input int xs, input int ym, input int ys);
    int qx, rx, qy, ry;
    logic sqx, srx, sqy, sry;
    if (dm == 0) return 37'd1;
    qx = xm / dm;  rx = xm % dm;
    qy = ym / dm;  ry = ym % dm;
    sqx = (qx != 0) && ((xs ^ ds) != 0);
    srx = (rx != 0) && (xs != 0);
    sqy = (qy != 0) && ((ys ^ ds) != 0);
    sry = (ry != 0) && (ys != 0);
    return {sqx, 8'(qx), srx, 8'(rx), sqy, 8'(qy), sry, 8'(ry), 1'b0};
  endfunction

  // Drives one operand set, then waits (bounded) for out_valid; lat counts edges incl. the accept edge.
  task automatic send(input int dm, input int ds, input int xm, input int xs,
                      input int ym, input int ys, output int lat);
    @(negedge clk);
    io.det_mag  = 8'(dm); io.det_sign = 1'(ds);
    io.dx_mag   = 8'(xm); io.dx_sign  = 1'(xs);
    io.dy_mag   = 8'(ym); io.dy_sign  = 1'(ys);
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", io.in_ready, io.out_valid);
    end
    checks++;
    if (got !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_out: got=%h want=0", got);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || got !== 37'd0) begin
      errors++;
      $display("[TB] FAIL post_reset: rdy=%b vld=%b got=%h want 1/0/0", io.in_ready, io.out_valid, got);
    end
  endtask

  task automatic test_directed();
    int tbl [7][6] = '{
      '{5,   0, 20,  0, 13,  1},
      '{3,   1, 255, 0, 0,   1},
      '{0,   1, 7,   0, 9,   0},
      '{1,   0, 200, 1, 3,   0},
      '{255, 0, 254, 1, 255, 0},
      '{1,   0, 255, 0, 128, 0},
      '{7,   1, 0,   1, 100, 1}};
    int lat, exp_lat;
    logic [36:0] exp;
    for (int i = 0; i < 7; i++) begin
      exp = model(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5]);
      exp_lat = (tbl[i][0] == 0) ? 1 : 2*W+1;
      send(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5], lat);
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("[TB] FAIL dir_latency[%0d]: got=%0d want=%0d", i, lat, exp_lat);
      end
      checks++;
      if (got !== exp || io.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dir_result[%0d]: got=%h rdy=%b want=%h rdy=0", i, got, io.in_ready, exp);
      end
      drain();
      checks++;
      if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dir_release[%0d]: rdy=%b vld=%b want 1/0", i, io.in_ready, io.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [36:0] exp;
    exp = model(9, 1, 250, 0, 77, 1);
    send(9, 1, 250, 0, 77, 1, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      io.in_valid = c[0];
      io.det_mag  = 8'($urandom_range(1, 255));
      io.dx_mag   = 8'($urandom);
      io.dy_mag   = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (got !== exp || io.in_ready !== 1'b0 || io.out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got=%h rdy=%b vld=%b want=%h 0/1", c, got, io.in_ready, io.out_valid, exp);
      end
    end
    drain();
    checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || got !== exp) begin
      errors++;
      $display("[TB] FAIL bp_release: rdy=%b vld=%b got=%h want 1/0/%h", io.in_ready, io.out_valid, got, exp);
    end
    exp = model(4, 0, 17, 1, 8, 0);
    send(4, 0, 17, 1, 8, 0, lat);
    checks++;
    if (lat !== 2*W+1 || got !== exp) begin
      errors++;
      $display("[TB] FAIL bp_next: lat=%0d got=%h want %0d/%h", lat, got, 2*W+1, exp);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [36:0] exp;
    @(negedge clk);
    io.det_mag = 8'd7; io.det_sign = 1'b0;
    io.dx_mag = 8'd200; io.dx_sign = 1'b1;
    io.dy_mag = 8'd50;  io.dy_sign = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || got !== 37'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: rdy=%b vld=%b got=%h want 1/0/0", io.in_ready, io.out_valid, got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = model(1, 0, 255, 0, 128, 0);
    send(1, 0, 255, 0, 128, 0, lat);
    checks++;
    if (lat !== 2*W+1 || got !== exp) begin
      errors++;
      $display("[TB] FAIL mid_reset_after: lat=%0d got=%h want %0d/%h", lat, got, 2*W+1, exp);
    end
    drain();
  endtask

  task automatic test_random();
    int dm, ds, xm, xs, ym, ys, lat, exp_lat;
    logic [36:0] exp;
    for (int i = 0; i < 40; i++) begin
      dm = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      ds = int'($urandom_range(0, 1));
      xm = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
      xs = int'($urandom_range(0, 1));
      ym = int'($urandom_range(0, 255));
      ys = int'($urandom_range(0, 1));
      exp = model(dm, ds, xm, xs, ym, ys);
      exp_lat = (dm == 0) ? 1 : 2*W+1;
      send(dm, ds, xm, xs, ym, ys, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (lat !== exp_lat || got !== exp || io.out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand[%0d] d=%0d/%0d x=%0d/%0d y=%0d/%0d: lat=%0d got=%h want %0d/%h",
                 i, dm, ds, xm, xs, ym, ys, lat, got, exp_lat, exp);
      end
      drain();
    end
  endtask

  initial begin
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.det_mag = '0; io.det_sign = 1'b0;
    io.dx_mag = '0;  io.dx_sign = 1'b0;
    io.dy_mag = '0;  io.dy_sign = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
